alu_multistate: RTL and testbench
=================================

# alu_multistate

Parametrised multi-cycle ALU for the processor datapath. It is the successor to the fixed 10-bit add/sub/and/or unit. The block latches operand A from the shared bus, computes `OP <fn> A` into result register G, and drives G back onto the bus through a tri-state output. It adds configurable width, xor/shift operations, a multi-cycle shift-add multiplier with Busy/Done handshake, and Z/C/V status flags.

## Interface
- W, 10, datapath width (≥4)
- CLKb  in  1  clock; all state updates on the falling edge
- RSTb  in  1  reset, asynchronous, active-low
- OP  in  W  data bus input; second operand / load value
- FN  in  4  function select, sampled with Gin
- Ain  in  1  load A from OP
- Gin  in  1  start operation; result goes to G
- Gout  in  1  drive G onto Q
- Q  out  W  G when Gout=1, else high-Z
- Busy  out  1  multiply in progress
- Done  out  1  one-cycle pulse when G is updated
- Zf, Cf, Vf  out  1 each  zero, carry/borrow, signed overflow of last result

## Operation
- Registers: A[W], G[W], flags, FSM state {IDLE, MUL}, counter cnt[$clog2(W+1)], multiplier working regs.
- Reset (async, RSTb=0): A=0, G=0, Zf=Cf=Vf=0, Busy=0, Done=0, state=IDLE, cnt=0. Q is high-Z, or 0 if Gout=1.
- Ain=1 in IDLE: A ← OP.
- Gin=1 in IDLE, with FN:
  - 0001 add: G=OP+A; Cf=carry-out; Vf=signed overflow.
  - 0010 sub: G=OP−A; Cf=1 iff OP<A unsigned; Vf=signed overflow.
  - 0100 and, 1000 or, 0011 xor: bitwise; Cf=Vf=0.
  - 0101 shl: G=A<<OP[$clog2(W)-1:0]. 0110 shr (logical): G=A>>same amount. Shift amount ≥W gives 0. Cf=last bit shifted out (0 if amount 0). Vf=0.
  - 0111 mul: enter MUL (see below).
  - Any other FN: G=0, Cf=Vf=0.
  - Zf=(new G==0) on every G update.
- MUL: unsigned shift-add over W cycles; multiplicand=A, multiplier=OP, both captured at start. Busy=1 throughout. On completion: G=low W bits of product, Cf=1 iff high W bits ≠0, Vf=0, return to IDLE.
- Ain and Gin in the same IDLE cycle: the operation uses the old A, and A takes the new OP.
- Ain and Gin are ignored while Busy=1; no queuing.
- Gout is independent of the FSM. During MUL, Q shows the previous G.
- Done=1 for exactly one cycle after each G update; otherwise 0.

## Timing
- Single-cycle ops: Gin sampled at falling edge n. G, flags and Done=1 are valid after edge n. Done clears after edge n+1.
- mul: Gin at edge n sets Busy=1 after edge n. G, flags and Done=1 update at edge n+W, where Busy returns to 0. Latency is W cycles.
- A new Gin is accepted at edge n+W+1 at the earliest after a mul. After single-cycle ops, Gin may be accepted every cycle (back-to-back).
- Q follows Gout combinationally: high-Z to driven with no clock delay.
- RSTb low mid-multiply: abort immediately. All registers take reset values, so G=0 and no Done pulse occurs.
- Counter wrap: cnt counts W down to 1 and never wraps during a legal operation.

## Test plan
- Reset: RSTb=0 with Gout=1 → Q=0, Busy=0, Done=0, flags 0. With Gout=0 → Q=Z.
- Add with wrap (W=10): Ain with OP=300, then Gin FN=0001 OP=200 → G=500, Cf=0, Done pulse, Q=500 with Gout. Then A=1000, OP=100 → G=76, Cf=1.
- Sub/flags: A=5, Gin FN=0010 OP=3 → G=1022, Cf=1, Vf=0. A=1, OP=511 → G=510, Vf=0. A=1, OP=512 → G=511, Vf=1.
- Shifts: A=0x201, FN=0101 OP=1 → G=0x002, Cf=1. FN=0110 OP=12 → G=0, Zf=1.
- Multiply: A=25, Gin FN=0111 OP=30 → Busy for 10 cycles, then G=750, Cf=0, one Done pulse. A=100, OP=20 → G=976, Cf=1.
- Busy/abort: during a mul, pulse Ain OP=7 and Gin → A and the result are unaffected. Assert RSTb=0 at cycle 5 → G=0, Busy=0, no Done.

Source files
------------

// File: rtl/alu_multistate.sv
// Multi-cycle ALU: latches A from the bus, computes OP <fn> A into G and drives G
// back onto the bus; multiply runs as a W-cycle shift-add sequence.
module alu_multistate #(
    parameter int unsigned W = 10
) (
    input  logic         CLKb,
    input  logic         RSTb,
    input  logic [W-1:0] OP,
    input  logic [3:0]   FN,
    input  logic         Ain,
    input  logic         Gin,
    input  logic         Gout,
    output logic [W-1:0] Q,
    output logic         Busy,
    output logic         Done,
    output logic         Zf,
    output logic         Cf,
    output logic         Vf
);

    localparam int unsigned SW = $clog2(W);
    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [3:0] FN_ADD = 4'b0001;
    localparam logic [3:0] FN_SUB = 4'b0010;
    localparam logic [3:0] FN_XOR = 4'b0011;
    localparam logic [3:0] FN_AND = 4'b0100;
    localparam logic [3:0] FN_SHL = 4'b0101;
    localparam logic [3:0] FN_SHR = 4'b0110;
    localparam logic [3:0] FN_MUL = 4'b0111;
    localparam logic [3:0] FN_OR  = 4'b1000;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state;
    logic [W-1:0]     a;
    logic [W-1:0]     g;
    logic [CW-1:0]    cnt;
    logic [2*W-1:0]   mcand;
    logic [2*W-1:0]   acc;
    logic [W-1:0]     mplier;

    logic [W-1:0]     res;
    logic             res_c;
    logic             res_v;
    logic [W:0]       sum_x;
    logic [W-1:0]     diff;
    logic [W:0]       shl_x;
    logic [W:0]       shr_x;
    logic [SW-1:0]    amt;
    logic [2*W-1:0]   prod_next;

    // Single-cycle result and flags; shifts carry an extra bit to catch the last bit out
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        amt   = OP[SW-1:0];
        sum_x = {1'b0, OP} + {1'b0, a};
        diff  = OP - a;
        shl_x = {1'b0, a} << amt;
        shr_x = {a, 1'b0} >> amt;
        case (FN)
            FN_ADD: begin
                res   = sum_x[W-1:0];
                res_c = sum_x[W];
                res_v = (OP[W-1] == a[W-1]) && (sum_x[W-1] != OP[W-1]);
            end
            FN_SUB: begin
                res   = diff;
                res_c = (OP < a);
                res_v = (OP[W-1] != a[W-1]) && (diff[W-1] != OP[W-1]);
            end
            FN_AND: res = OP & a;
            FN_OR:  res = OP | a;
            FN_XOR: res = OP ^ a;
            FN_SHL: begin
                res   = shl_x[W-1:0];
                res_c = shl_x[W];
            end
            FN_SHR: begin
                res   = shr_x[W:1];
                res_c = shr_x[0];
            end
            default: begin
                res   = '0;
                res_c = 1'b0;
            end
        endcase
    end

    // Next partial product for the current multiplier bit
    always_comb begin
        prod_next = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state  <= S_IDLE;
            a      <= '0;
            g      <= '0;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Zf     <= 1'b0;
            Cf     <= 1'b0;
            Vf     <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Ain) a <= OP;
                    if (Gin) begin
                        if (FN == FN_MUL) begin
                            state  <= S_MUL;
                            Busy   <= 1'b1;
                            cnt    <= CW'(W);
                            mcand  <= {{W{1'b0}}, a};
                            mplier <= OP;
                            acc    <= '0;
                        end else begin
                            g    <= res;
                            Cf   <= res_c;
                            Vf   <= res_v;
                            Zf   <= (res == '0);
                            Done <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= S_IDLE;
                        Busy  <= 1'b0;
                        g     <= prod_next[W-1:0];
                        Cf    <= |prod_next[2*W-1:W];
                        Vf    <= 1'b0;
                        Zf    <= (prod_next[W-1:0] == '0);
                        Done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Q = Gout ? g : {W{1'bz}};

endmodule

// File: tb/tb_alu_multistate.sv
// Directed bench for alu_multistate: single-cycle ops, flags, multiply, busy-ignore and abort.
module tb_alu_multistate;

    localparam int unsigned W = 10;

    logic         clkb = 1'b1;
    logic         rstb = 1'b0;
    logic [W-1:0] op   = '0;
    logic [3:0]   fn   = '0;
    logic         ain  = 1'b0;
    logic         gin  = 1'b0;
    logic         gout = 1'b1;
    wire  [W-1:0] q;
    logic         busy, done, zf, cf, vf;

    int n_cmp = 0;
    int n_err = 0;

    alu_multistate #(.W(W)) dut (
        .CLKb(clkb), .RSTb(rstb), .OP(op), .FN(fn), .Ain(ain), .Gin(gin), .Gout(gout),
        .Q(q), .Busy(busy), .Done(done), .Zf(zf), .Cf(cf), .Vf(vf)
    );

    always #5 clkb = ~clkb;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the active (falling) edge and settle
    task automatic step();
        @(negedge clkb);
        #1;
    endtask

    task automatic load(input logic [W-1:0] v);
        ain = 1'b1; op = v;
        step();
        ain = 1'b0;
    endtask

    task automatic run(input logic [3:0] f, input logic [W-1:0] v);
        gin = 1'b1; fn = f; op = v;
        step();
        gin = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [W-1:0] g, input logic c,
                           input logic v, input logic z);
        check({tag, "_q"}, q, g);
        check({tag, "_c"}, W'(cf), W'(c));
        check({tag, "_v"}, W'(vf), W'(v));
        check({tag, "_z"}, W'(zf), W'(z));
        check({tag, "_done"}, W'(done), W'(1'b1));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!done && lat < 40);
    endtask

    initial begin
        int lat;
        int dcount;

        #12;
        check("rst_q", q, '0);
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_flags", W'({zf, cf, vf}), '0);
        rstb = 1'b1;
        step();

        // add, including carry-out wrap
        load(10'd300);
        run(4'b0001, 10'd200);
        chk_res("add1", 10'd500, 1'b0, 1'b0, 1'b0);
        step();
        check("done_clear", W'(done), '0);
        load(10'd1000);
        run(4'b0001, 10'd100);
        chk_res("add2", 10'd76, 1'b1, 1'b0, 1'b0);

        // sub with borrow and signed overflow
        load(10'd5);
        run(4'b0010, 10'd3);
        chk_res("sub1", 10'd1022, 1'b1, 1'b0, 1'b0);
        load(10'd1);
        run(4'b0010, 10'd511);
        chk_res("sub2", 10'd510, 1'b0, 1'b0, 1'b0);
        run(4'b0010, 10'd512);
        chk_res("sub3", 10'd511, 1'b0, 1'b1, 1'b0);

        // shifts, out-of-range amount
        load(10'h201);
        run(4'b0101, 10'd1);
        chk_res("shl1", 10'h002, 1'b1, 1'b0, 1'b0);
        run(4'b0110, 10'd12);
        chk_res("shr12", 10'h000, 1'b0, 1'b0, 1'b1);
        run(4'b0110, 10'd1);
        chk_res("shr1", 10'h100, 1'b1, 1'b0, 1'b0);

        // logic ops back-to-back, then an undefined FN
        load(10'h3F0);
        run(4'b0011, 10'h0FF);
        chk_res("xor", 10'h30F, 1'b0, 1'b0, 1'b0);
        run(4'b0100, 10'h0FF);
        chk_res("and", 10'h0F0, 1'b0, 1'b0, 1'b0);
        run(4'b1000, 10'h00F);
        chk_res("or", 10'h3FF, 1'b0, 1'b0, 1'b0);
        run(4'b1111, 10'h0FF);
        chk_res("badfn", 10'h000, 1'b0, 1'b0, 1'b1);

        // Ain with Gin: op uses old A, A takes new OP
        load(10'd10);
        ain = 1'b1;
        run(4'b0001, 10'd5);
        ain = 1'b0;
        chk_res("ag_same", 10'd15, 1'b0, 1'b0, 1'b0);
        run(4'b0001, 10'd0);
        chk_res("ag_newa", 10'd5, 1'b0, 1'b0, 1'b0);

        // multiply: W-cycle latency, Q holds previous G meanwhile
        load(10'd25);
        run(4'b0111, 10'd30);
        check("mul_busy", W'(busy), W'(1'b1));
        check("mul_qhold", q, 10'd5);
        wait_done(lat);
        check("mul_lat", W'(lat), W'(W));
        check("mul_busy_end", W'(busy), '0);
        chk_res("mul1", 10'd750, 1'b0, 1'b0, 1'b0);
        step();
        check("mul_done_clear", W'(done), '0);
        load(10'd100);
        run(4'b0111, 10'd20);
        wait_done(lat);
        chk_res("mul2", 10'd976, 1'b1, 1'b0, 1'b0);

        // Ain/Gin ignored while busy
        load(10'd25);
        run(4'b0111, 10'd30);
        ain = 1'b1; gin = 1'b1; fn = 4'b0001; op = 10'd7;
        step();
        ain = 1'b0; gin = 1'b0;
        wait_done(lat);
        check("ign_lat", W'(lat), W'(W - 1));
        chk_res("ign_mul", 10'd750, 1'b0, 1'b0, 1'b0);
        step();
        check("ign_nodone", W'(done), '0);
        run(4'b0001, 10'd0);
        chk_res("ign_a", 10'd25, 1'b0, 1'b0, 1'b0);

        // reset mid-multiply aborts with no Done
        load(10'd3);
        run(4'b0111, 10'd3);
        for (int i = 0; i < 4; i++) step();
        rstb = 1'b0;
        #1;
        check("abort_q", q, '0);
        check("abort_busy", W'(busy), '0);
        check("abort_done", W'(done), '0);
        #1;
        rstb = 1'b1;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) dcount++;
        end
        check("abort_nodone", W'(dcount), '0);
        check("abort_qhold", q, '0);
        run(4'b0001, 10'd0);
        chk_res("abort_a", 10'd0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
